// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, trim FSM state and ns/sec normalisation for rtc_multi_pps
//
// Contents:
//   NS_PER_SEC    : nanoseconds per second (64-bit).
//   NS_PER_SEC_30 : the same constant sized to the 30-bit integer-ns field.
//   trim_state_t  : IDLE/ACTIVE state of the frequency-trim window FSM.
//   ns_sec_t      : wide signed ns / unsigned sec pair used during arithmetic.
//   normalise()   : folds an out-of-range ns value back into [0, one_sec).
//                   Each fold moves one second into or out of sec.
package rtc_pkg;

    localparam logic [63:0] NS_PER_SEC    = 64'd1_000_000_000;
    localparam logic [29:0] NS_PER_SEC_30 = 30'd1_000_000_000;

    typedef enum logic {
        TRIM_IDLE   = 1'b0,
        TRIM_ACTIVE = 1'b1
    } trim_state_t;

    typedef struct packed {
        logic signed [63:0] ns;
        logic [63:0]        sec;
    } ns_sec_t;

    // Two folds cover every case the clock produces: an add of
    // ns + period + clamped offset stays below 3 s, and a subtract of a
    // clamped offset stays above -1 s.
    function automatic ns_sec_t normalise(input logic signed [63:0] ns,
                                          input logic [63:0]        sec,
                                          input logic signed [63:0] one_sec);
        ns_sec_t r;
        r.ns  = ns;
        r.sec = sec;
        for (int i = 0; i < 2; i++) begin
            if (r.ns < 0) begin
                r.ns  = r.ns + one_sec;
                r.sec = r.sec - 64'd1;
            end else if (r.ns >= one_sec) begin
                r.ns  = r.ns - one_sec;
                r.sec = r.sec + 64'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_pulse_gen.sv
// rtl/rtc_pulse_gen.sv - phase-crossing detector with a fixed-width pulse stretcher
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset.
//   en         : crossing detection enable. It is held low for one cycle after a time step.
//   prev_ns    : integer ns of the previous cycle.
//   cur_ns     : integer ns of the current cycle.
//   phase      : ns phase to detect. A value >= 1e9 disables the channel.
//   pulse      : registered pulse, PULSE_CYC cycles wide.
//                A re-trigger restarts the pulse width.
module rtc_pulse_gen
    import rtc_pkg::*;
#(
    parameter int PULSE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [29:0] prev_ns,
    input  logic [29:0] cur_ns,
    input  logic [29:0] phase,
    output logic        pulse
);

    localparam int CNT_W = $clog2(PULSE_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             fire;

    // A backwards move of ns is a second wrap; after a wrap only
    // phases already reached in the new second count as crossed.
    always_comb begin
        fire = 1'b0;
        if (en && (phase < NS_PER_SEC_30)) begin
            if (cur_ns >= prev_ns) begin
                fire = (prev_ns < phase) && (phase <= cur_ns);
            end else begin
                fire = (phase <= cur_ns);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (fire) begin
            cnt   <= CNT_W'(PULSE_CYC - 1);
            pulse <= 1'b1;
        end else if (cnt != '0) begin
            cnt   <= cnt - CNT_W'(1);
            pulse <= 1'b1;
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_multi_pps.sv
// rtl/rtc_multi_pps.sv - fractional-ns PTP time counter with trim, offset steps and N phase pulses
//
// Ports:
//   clk, rst_n                 : clock and asynchronous active-low reset.
//   time_ld, time_reg_*_in     : absolute time load. It has the highest priority.
//   period_ld, period_in       : nominal per-cycle increment, in ns with NS_FRAC_W fraction bits.
//   adj_ld, adj_ld_data,
//   period_adj, adj_ld_done    : timed frequency trim window. Done pulses when the window ends.
//   offset_ld, offset_ptp_*_in : signed offset step. It is registered, then applied one cycle later.
//   pps_phase_in               : per-channel 30-bit ns phase.
//   time_reg_ns/sec            : current time.
//   time_ptp_ns/sec            : integer-ns view of the current time.
//   time_one_pps               : pulse generated at each second rollover.
//   pps_out                    : per-channel phase pulses.
// Optional (macro RTC_SNAPSHOT_EN):
//   snap_req                   : on its rising edge, captures time_ptp_ns/sec into snap_ns/snap_sec.
//   snap_valid                 : rises one cycle after the capture and stays high until the next request.
module rtc_multi_pps
    import rtc_pkg::*;
#(
    parameter int NS_FRAC_W = 8,
    parameter int SEC_W     = 48,
    parameter int PERIOD_W  = 40,
    parameter int N_PPS     = 2,
    parameter int PULSE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    time_ld,
    input  logic [30+NS_FRAC_W-1:0] time_reg_ns_in,
    input  logic [SEC_W-1:0]        time_reg_sec_in,
    input  logic                    period_ld,
    input  logic [PERIOD_W-1:0]     period_in,
    input  logic                    adj_ld,
    input  logic [31:0]             adj_ld_data,
    input  logic [PERIOD_W-1:0]     period_adj,
    output logic                    adj_ld_done,
    input  logic                    offset_ld,
    input  logic [31:0]             offset_ptp_ns_in,
    input  logic [SEC_W-1:0]        offset_ptp_sec_in,
    input  logic [N_PPS*30-1:0]     pps_phase_in,
    output logic [30+NS_FRAC_W-1:0] time_reg_ns,
    output logic [SEC_W-1:0]        time_reg_sec,
    output logic [31:0]             time_ptp_ns,
    output logic [SEC_W-1:0]        time_ptp_sec,
    output logic                    time_one_pps,
    output logic [N_PPS-1:0]        pps_out
`ifdef RTC_SNAPSHOT_EN
    ,
    input  logic                    snap_req,
    output logic [31:0]             snap_ns,
    output logic [SEC_W-1:0]        snap_sec,
    output logic                    snap_valid
`endif
);

    localparam int                 NS_W       = 30 + NS_FRAC_W;
    localparam logic signed [63:0] ONE_SEC    = $signed(NS_PER_SEC << NS_FRAC_W);
    localparam logic [31:0]        OFF_NS_MAX = 32'd999_999_999;

    logic [NS_W-1:0]     ns_q;
    logic [SEC_W-1:0]    sec_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] adj_q;
    logic [31:0]         adj_cnt;
    trim_state_t         trim_state;
    logic                done_q;

    logic                off_valid_q;
    logic                off_sub_q;
    logic [31:0]         off_ns_q;
    logic [SEC_W-2:0]    off_sec_q;

    logic                step_q;
    logic [29:0]         prev_ns_q;

    logic                apply_off;
    logic signed [63:0]  incr;
    logic signed [63:0]  ns_sum;
    logic signed [63:0]  off_ns_ext;
    logic [63:0]         sec_sum;
    logic [63:0]         off_sec_ext;
    ns_sec_t             nrm;
    logic [NS_W-1:0]     ns_next;
    logic [SEC_W-1:0]    sec_next;

    // A pending offset is dropped when time_ld hits its apply cycle.
    always_comb begin
        apply_off = off_valid_q & ~time_ld;
        incr      = $signed({{(64-PERIOD_W){1'b0}}, period_q});
        if (trim_state == TRIM_ACTIVE) begin
            incr = incr + $signed({{(64-PERIOD_W){adj_q[PERIOD_W-1]}}, adj_q});
        end
        ns_sum      = $signed({{(64-NS_W){1'b0}}, ns_q}) + incr;
        sec_sum     = {{(64-SEC_W){1'b0}}, sec_q};
        off_ns_ext  = $signed(64'(off_ns_q) << NS_FRAC_W);
        off_sec_ext = {{(65-SEC_W){1'b0}}, off_sec_q};
        if (apply_off) begin
            if (off_sub_q) begin
                ns_sum  = ns_sum - off_ns_ext;
                sec_sum = sec_sum - off_sec_ext;
            end else begin
                ns_sum  = ns_sum + off_ns_ext;
                sec_sum = sec_sum + off_sec_ext;
            end
        end
        nrm      = normalise(ns_sum, sec_sum, ONE_SEC);
        ns_next  = NS_W'(nrm.ns);
        sec_next = SEC_W'(nrm.sec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_q        <= '0;
            sec_q       <= '0;
            period_q    <= '0;
            off_valid_q <= 1'b0;
            off_sub_q   <= 1'b0;
            off_ns_q    <= '0;
            off_sec_q   <= '0;
            step_q      <= 1'b0;
            prev_ns_q   <= '0;
        end else begin
            prev_ns_q   <= ns_q[NS_W-1:NS_FRAC_W];
            step_q      <= time_ld | apply_off;
            off_valid_q <= offset_ld;
            if (period_ld) begin
                period_q <= period_in;
            end
            if (offset_ld) begin
                off_sub_q <= offset_ptp_sec_in[SEC_W-1];
                off_sec_q <= offset_ptp_sec_in[SEC_W-2:0];
                off_ns_q  <= (offset_ptp_ns_in > OFF_NS_MAX) ? OFF_NS_MAX : offset_ptp_ns_in;
            end
            if (time_ld) begin
                ns_q  <= time_reg_ns_in;
                sec_q <= time_reg_sec_in;
            end else begin
                ns_q  <= ns_next;
                sec_q <= sec_next;
            end
        end
    end

    // A new adj_ld always restarts the window. Data 0 only produces done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trim_state <= TRIM_IDLE;
            adj_cnt    <= '0;
            adj_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (adj_ld) begin
                adj_q   <= period_adj;
                adj_cnt <= adj_ld_data;
                if (adj_ld_data == 32'd0) begin
                    trim_state <= TRIM_IDLE;
                    done_q     <= 1'b1;
                end else begin
                    trim_state <= TRIM_ACTIVE;
                end
            end else if (trim_state == TRIM_ACTIVE) begin
                adj_cnt <= adj_cnt - 32'd1;
                if (adj_cnt == 32'd1) begin
                    trim_state <= TRIM_IDLE;
                    done_q     <= 1'b1;
                end
            end
        end
    end

    assign adj_ld_done  = done_q;
    assign time_reg_ns  = ns_q;
    assign time_reg_sec = sec_q;
    assign time_ptp_ns  = {2'b00, ns_q[NS_W-1:NS_FRAC_W]};
    assign time_ptp_sec = sec_q;

    // Phase 0 fires only on a wrap, which makes this channel the rollover pulse.
    rtc_pulse_gen #(.PULSE_CYC(PULSE_CYC)) u_one_pps (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (~step_q),
        .prev_ns (prev_ns_q),
        .cur_ns  (ns_q[NS_W-1:NS_FRAC_W]),
        .phase   (30'd0),
        .pulse   (time_one_pps)
    );

    for (genvar g = 0; g < N_PPS; g++) begin : g_pps
        rtc_pulse_gen #(.PULSE_CYC(PULSE_CYC)) u_pps (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (~step_q),
            .prev_ns (prev_ns_q),
            .cur_ns  (ns_q[NS_W-1:NS_FRAC_W]),
            .phase   (pps_phase_in[g*30 +: 30]),
            .pulse   (pps_out[g])
        );
    end

`ifdef RTC_SNAPSHOT_EN
    logic snap_req_q;
    logic snap_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_req_q <= 1'b0;
            snap_pend  <= 1'b0;
            snap_ns    <= '0;
            snap_sec   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_req_q <= snap_req;
            snap_pend  <= 1'b0;
            if (snap_req && !snap_req_q) begin
                snap_ns    <= time_ptp_ns;
                snap_sec   <= sec_q;
                snap_valid <= 1'b0;
                snap_pend  <= 1'b1;
            end else if (snap_pend) begin
                snap_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtc_multi_pps.sv
// tb/tb_rtc_multi_pps.sv - directed self-checking bench for rtc_multi_pps
module tb_rtc_multi_pps;

    localparam int NS_FRAC_W = 8;
    localparam int SEC_W     = 48;
    localparam int PERIOD_W  = 40;
    localparam int N_PPS     = 2;
    localparam int PULSE_CYC = 4;
    localparam int NS_W      = 30 + NS_FRAC_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                time_ld;
    logic [NS_W-1:0]     time_reg_ns_in;
    logic [SEC_W-1:0]    time_reg_sec_in;
    logic                period_ld;
    logic [PERIOD_W-1:0] period_in;
    logic                adj_ld;
    logic [31:0]         adj_ld_data;
    logic [PERIOD_W-1:0] period_adj;
    logic                adj_ld_done;
    logic                offset_ld;
    logic [31:0]         offset_ptp_ns_in;
    logic [SEC_W-1:0]    offset_ptp_sec_in;
    logic [N_PPS*30-1:0] pps_phase_in;
    logic [NS_W-1:0]     time_reg_ns;
    logic [SEC_W-1:0]    time_reg_sec;
    logic [31:0]         time_ptp_ns;
    logic [SEC_W-1:0]    time_ptp_sec;
    logic                time_one_pps;
    logic [N_PPS-1:0]    pps_out;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_ns;

    always #5 clk = ~clk;

    rtc_multi_pps #(
        .NS_FRAC_W (NS_FRAC_W),
        .SEC_W     (SEC_W),
        .PERIOD_W  (PERIOD_W),
        .N_PPS     (N_PPS),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .time_ld           (time_ld),
        .time_reg_ns_in    (time_reg_ns_in),
        .time_reg_sec_in   (time_reg_sec_in),
        .period_ld         (period_ld),
        .period_in         (period_in),
        .adj_ld            (adj_ld),
        .adj_ld_data       (adj_ld_data),
        .period_adj        (period_adj),
        .adj_ld_done       (adj_ld_done),
        .offset_ld         (offset_ld),
        .offset_ptp_ns_in  (offset_ptp_ns_in),
        .offset_ptp_sec_in (offset_ptp_sec_in),
        .pps_phase_in      (pps_phase_in),
        .time_reg_ns       (time_reg_ns),
        .time_reg_sec      (time_reg_sec),
        .time_ptp_ns       (time_ptp_ns),
        .time_ptp_sec      (time_ptp_sec),
        .time_one_pps      (time_one_pps),
        .pps_out           (pps_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NS_W-1:0] fx(input longint n);
        return NS_W'(n << NS_FRAC_W);
    endfunction

    task automatic clear_ctrl();
        time_ld   = 1'b0;
        period_ld = 1'b0;
        adj_ld    = 1'b0;
        offset_ld = 1'b0;
    endtask

    task automatic test_reset();
        clear_ctrl();
        time_reg_ns_in    = '0;
        time_reg_sec_in   = '0;
        period_in         = '0;
        adj_ld_data       = '0;
        period_adj        = '0;
        offset_ptp_ns_in  = '0;
        offset_ptp_sec_in = '0;
        pps_phase_in      = '0;
        rst_n = 1'b0;
        #2;
        n_checks++; if (time_reg_ns !== '0) begin n_fail++; $display("FAIL reset_ns: got %0d expected 0", time_reg_ns); end
        n_checks++; if (time_reg_sec !== '0) begin n_fail++; $display("FAIL reset_sec: got %0d expected 0", time_reg_sec); end
        n_checks++; if (time_ptp_ns !== 32'd0) begin n_fail++; $display("FAIL reset_ptp_ns: got %0d expected 0", time_ptp_ns); end
        n_checks++; if ({time_one_pps, pps_out, adj_ld_done} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {time_one_pps, pps_out, adj_ld_done}); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (time_reg_ns !== '0) begin n_fail++; $display("FAIL reset_period0: got %0d expected 0", time_reg_ns); end
    endtask

    task automatic test_rollover();
        pps_phase_in    = {30'd1_000_000_000, 30'd1000};
        period_ld       = 1'b1;
        period_in       = 40'd2048;
        time_ld         = 1'b1;
        time_reg_ns_in  = fx(999_999_992);
        time_reg_sec_in = 48'd5;
        tick();
        clear_ctrl();
        n_checks++; if (time_ptp_ns !== 32'd999_999_992) begin n_fail++; $display("FAIL roll_load_ns: got %0d expected 999999992", time_ptp_ns); end
        tick();
        n_checks++; if (time_reg_ns !== fx(0)) begin n_fail++; $display("FAIL roll_ns: got %0d expected 0", time_reg_ns); end
        n_checks++; if (time_reg_sec !== 48'd6 || time_ptp_sec !== 48'd6) begin n_fail++; $display("FAIL roll_sec: got %0d/%0d expected 6", time_reg_sec, time_ptp_sec); end
        n_checks++; if (time_one_pps !== 1'b0) begin n_fail++; $display("FAIL roll_pps_early: got %b expected 0", time_one_pps); end
        for (int i = 1; i <= PULSE_CYC; i++) begin
            tick();
            n_checks++; if (time_one_pps !== 1'b1) begin n_fail++; $display("FAIL roll_pps_width[%0d]: got %b expected 1", i, time_one_pps); end
            n_checks++; if (time_ptp_ns !== 32'(8 * i)) begin n_fail++; $display("FAIL roll_step[%0d]: got %0d expected %0d", i, time_ptp_ns, 8 * i); end
        end
        tick();
        n_checks++; if (time_one_pps !== 1'b0) begin n_fail++; $display("FAIL roll_pps_end: got %b expected 0", time_one_pps); end
    endtask

    task automatic test_offset();
        time_ld           = 1'b1;
        time_reg_ns_in    = fx(100);
        time_reg_sec_in   = 48'd10;
        offset_ld         = 1'b1;
        offset_ptp_sec_in = 48'h8000_0000_0001;
        offset_ptp_ns_in  = 32'd0;
        tick();
        clear_ctrl();
        n_checks++; if (time_ptp_ns !== 32'd100 || time_reg_sec !== 48'd10) begin n_fail++; $display("FAIL off_load: got %0d.%0d expected 10.100", time_reg_sec, time_ptp_ns); end
        tick();
        n_checks++; if (time_reg_ns !== fx(108) || time_reg_sec !== 48'd9) begin n_fail++; $display("FAIL off_sub_sec: got %0d.%0d expected 9.108", time_reg_sec, time_ptp_ns); end
        tick();
        n_checks++; if (time_ptp_ns !== 32'd116 || time_reg_sec !== 48'd9) begin n_fail++; $display("FAIL off_once: got %0d.%0d expected 9.116", time_reg_sec, time_ptp_ns); end
        // add with the ns magnitude clamped to 999999999 and one carry
        offset_ld         = 1'b1;
        offset_ptp_sec_in = 48'd2;
        offset_ptp_ns_in  = 32'd2_000_000_000;
        tick();
        clear_ctrl();
        tick();
        n_checks++; if (time_ptp_ns !== 32'd131 || time_reg_sec !== 48'd12) begin n_fail++; $display("FAIL off_add_clamp: got %0d.%0d expected 12.131", time_reg_sec, time_ptp_ns); end
        // back-to-back subtracts, the first borrows a second and jumps over phase 1000
        offset_ld         = 1'b1;
        offset_ptp_sec_in = {1'b1, 47'd0};
        offset_ptp_ns_in  = 32'd500;
        tick();
        tick();
        clear_ctrl();
        n_checks++; if (time_ptp_ns !== 32'd999_999_647 || time_reg_sec !== 48'd11) begin n_fail++; $display("FAIL off_borrow: got %0d.%0d expected 11.999999647", time_reg_sec, time_ptp_ns); end
        tick();
        n_checks++; if (time_ptp_ns !== 32'd999_999_155 || time_reg_sec !== 48'd11) begin n_fail++; $display("FAIL off_b2b: got %0d.%0d expected 11.999999155", time_reg_sec, time_ptp_ns); end
        n_checks++; if (pps_out !== 2'b00) begin n_fail++; $display("FAIL off_step_pps: got %b expected 00", pps_out); end
        tick();
        n_checks++; if (time_ptp_ns !== 32'd999_999_163) begin n_fail++; $display("FAIL off_after: got %0d expected 999999163", time_ptp_ns); end
        n_checks++; if (pps_out !== 2'b00 || time_one_pps !== 1'b0) begin n_fail++; $display("FAIL off_step_quiet: got %b/%b expected 00/0", pps_out, time_one_pps); end
    endtask

    task automatic test_discard();
        pps_phase_in      = {30'd1_000_000_000, 30'd500};
        time_ld           = 1'b1;
        time_reg_ns_in    = fx(100);
        time_reg_sec_in   = 48'd10;
        offset_ld         = 1'b1;
        offset_ptp_sec_in = 48'd3;
        offset_ptp_ns_in  = 32'd5000;
        tick();
        offset_ld         = 1'b0;
        time_reg_ns_in    = fx(1000);
        time_reg_sec_in   = 48'd20;
        tick();
        clear_ctrl();
        n_checks++; if (time_reg_ns !== fx(1000) || time_reg_sec !== 48'd20) begin n_fail++; $display("FAIL disc_load: got %0d.%0d expected 20.1000", time_reg_sec, time_ptp_ns); end
        exp_ns = 1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ns += 8;
            n_checks++; if (time_reg_ns !== fx(exp_ns) || time_reg_sec !== 48'd20) begin n_fail++; $display("FAIL disc_time[%0d]: got %0d.%0d expected 20.%0d", i, time_reg_sec, time_ptp_ns, exp_ns); end
            n_checks++; if (pps_out !== 2'b00) begin n_fail++; $display("FAIL disc_pps[%0d]: got %b expected 00", i, pps_out); end
        end
    endtask

    task automatic test_trim();
        time_ld         = 1'b1;
        time_reg_ns_in  = fx(0);
        time_reg_sec_in = 48'd0;
        tick();
        clear_ctrl();
        adj_ld      = 1'b1;
        adj_ld_data = 32'd4;
        period_adj  = 40'd256;
        tick();
        adj_ld = 1'b0;
        exp_ns = 8;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_start: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_ns += 9;
            n_checks++; if (time_reg_ns !== fx(exp_ns)) begin n_fail++; $display("FAIL trim_ns[%0d]: got %0d expected %0d", i, time_ptp_ns, exp_ns); end
            n_checks++; if (adj_ld_done !== (i == 4)) begin n_fail++; $display("FAIL trim_done[%0d]: got %b expected %b", i, adj_ld_done, (i == 4)); end
        end
        tick();
        exp_ns += 8;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_after: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
        // zero-length window
        adj_ld      = 1'b1;
        adj_ld_data = 32'd0;
        tick();
        adj_ld = 1'b0;
        exp_ns += 8;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b1) begin n_fail++; $display("FAIL trim_zero: got %0d/%b expected %0d/1", time_ptp_ns, adj_ld_done, exp_ns); end
        tick();
        exp_ns += 8;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_zero_end: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
        // restart while active
        adj_ld      = 1'b1;
        adj_ld_data = 32'd3;
        tick();
        adj_ld = 1'b0;
        exp_ns += 8;
        tick();
        exp_ns += 9;
        adj_ld      = 1'b1;
        adj_ld_data = 32'd2;
        tick();
        adj_ld = 1'b0;
        exp_ns += 9;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_restart: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
        tick();
        exp_ns += 9;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_abort_nodone: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
        tick();
        exp_ns += 9;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b1) begin n_fail++; $display("FAIL trim_restart_done: got %0d/%b expected %0d/1", time_ptp_ns, adj_ld_done, exp_ns); end
        tick();
        exp_ns += 8;
        n_checks++; if (time_reg_ns !== fx(exp_ns) || adj_ld_done !== 1'b0) begin n_fail++; $display("FAIL trim_restart_end: got %0d/%b expected %0d/0", time_ptp_ns, adj_ld_done, exp_ns); end
    endtask

    task automatic test_pps();
        logic early;
        logic ch1_seen;
        logic one_seen;
        pps_phase_in    = {30'd1_000_000_000, 30'd1000};
        time_ld         = 1'b1;
        time_reg_ns_in  = fx(0);
        time_reg_sec_in = 48'd0;
        tick();
        clear_ctrl();
        early = 1'b0;
        for (int k = 1; k <= 125; k++) begin
            tick();
            if (pps_out !== 2'b00) early = 1'b1;
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL pps_early: got 1 expected 0"); end
        n_checks++; if (time_ptp_ns !== 32'd1000) begin n_fail++; $display("FAIL pps_reach: got %0d expected 1000", time_ptp_ns); end
        for (int k = 126; k <= 129; k++) begin
            tick();
            n_checks++; if (pps_out !== 2'b01) begin n_fail++; $display("FAIL pps_width[%0d]: got %b expected 01", k, pps_out); end
        end
        tick();
        n_checks++; if (pps_out !== 2'b00) begin n_fail++; $display("FAIL pps_end: got %b expected 00", pps_out); end
        // channel 1 (phase 1e9) must stay silent across a rollover
        time_ld         = 1'b1;
        time_reg_ns_in  = fx(999_999_984);
        time_reg_sec_in = 48'd7;
        tick();
        clear_ctrl();
        ch1_seen = 1'b0;
        one_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (pps_out[1] !== 1'b0) ch1_seen = 1'b1;
            if (time_one_pps === 1'b1) one_seen = 1'b1;
        end
        n_checks++; if (ch1_seen !== 1'b0) begin n_fail++; $display("FAIL pps_phase_1e9: got 1 expected 0"); end
        n_checks++; if (one_seen !== 1'b1 || time_reg_sec !== 48'd8) begin n_fail++; $display("FAIL pps_wrap_one_pps: got %b sec %0d expected 1 sec 8", one_seen, time_reg_sec); end
    endtask

    task automatic test_reset_mid_trim();
        logic done_seen;
        time_ld         = 1'b1;
        time_reg_ns_in  = fx(999_999_990);
        time_reg_sec_in = 48'd3;
        adj_ld          = 1'b1;
        adj_ld_data     = 32'd10;
        period_adj      = 40'd256;
        tick();
        clear_ctrl();
        tick();
        tick();
        tick();
        n_checks++; if (time_one_pps !== 1'b1 || time_ptp_ns !== 32'd17 || time_reg_sec !== 48'd4) begin n_fail++; $display("FAIL rst_pre: got pps %b %0d.%0d expected 1 4.17", time_one_pps, time_reg_sec, time_ptp_ns); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (time_reg_ns !== '0 || time_reg_sec !== '0 || time_ptp_ns !== 32'd0) begin n_fail++; $display("FAIL rst_async_time: got %0d.%0d expected 0.0", time_reg_sec, time_reg_ns); end
        n_checks++; if ({time_one_pps, pps_out, adj_ld_done} !== 4'b0) begin n_fail++; $display("FAIL rst_async_pulses: got %b expected 0000", {time_one_pps, pps_out, adj_ld_done}); end
        tick();
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (adj_ld_done !== 1'b0) done_seen = 1'b1;
        end
        n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got 1 expected 0"); end
        n_checks++; if (time_reg_ns !== '0 || time_reg_sec !== '0) begin n_fail++; $display("FAIL rst_frozen: got %0d.%0d expected 0.0", time_reg_sec, time_reg_ns); end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_offset();
        test_discard();
        test_trim();
        test_pps();
        test_reset_mid_trim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
